// File: rtl/data_sram_responder.sv
// Responder for the CPU data-SRAM port: a word-addressed RAM plus a small config-register
// window (LED, switches, timer, scratch), with registered read-first read data.
module data_sram_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch
);

    localparam int DEPTH = 1 << RAM_AW;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_SCRATCH = 16'h000C;

    logic [31:0] ram_mem [DEPTH];

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] scratch_q, scratch_d;
    logic [7:0]  sw_meta_q, sw_meta_d;
    logic [7:0]  sw_sync_q, sw_sync_d;

    logic              conf_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]       conf_off;
    logic [31:0]       ram_rd;
    logic [31:0]       timer_inc;
    logic [31:0]       rd_val;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strobe);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strobe[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign conf_hit = (data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign ram_idx  = data_sram_addr[RAM_AW+1:2];
    assign conf_off = data_sram_addr[15:0];

    always_comb begin
        ram_rd    = ram_mem[ram_idx];
        timer_inc = timer_q + 32'd1;
        sw_meta_d = switch;
        sw_sync_d = sw_meta_q;
        led_d     = led_q;
        timer_d   = timer_inc;
        scratch_d = scratch_q;
        rdata_d   = rdata_q;
        rd_val    = 32'd0;

        // Read value always reflects state before this edge's write (read-first).
        if (conf_hit) begin
            case (conf_off)
                OFF_LED:     rd_val = {16'd0, led_q};
                OFF_SWITCH:  rd_val = {24'd0, sw_sync_q};
                OFF_TIMER:   rd_val = timer_q;
                OFF_SCRATCH: rd_val = scratch_q;
                default:     rd_val = 32'd0;
            endcase
        end else begin
            rd_val = ram_rd;
        end

        if (data_sram_en) begin
            rdata_d = rd_val;
        end

        // A timer write overrides only the strobed bytes of the incremented value.
        if (data_sram_en && conf_hit) begin
            case (conf_off)
                OFF_LED: begin
                    if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
                    if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
                end
                OFF_TIMER:   timer_d   = merge_bytes(timer_inc, data_sram_wdata, data_sram_we);
                OFF_SCRATCH: scratch_d = merge_bytes(scratch_q, data_sram_wdata, data_sram_we);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= 32'd0;
            led_q     <= 16'd0;
            timer_q   <= 32'd0;
            scratch_q <= 32'd0;
            sw_meta_q <= 8'd0;
            sw_sync_q <= 8'd0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    // RAM contents survive reset, so the array lives in its own unreset block.
    always_ff @(posedge clk) begin
        if (data_sram_en && !conf_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    ram_mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;

endmodule
